// File: rtl/demux_pkg.sv
// Shared constants and the select decode for the four-way dispatch demux.
package demux_pkg;

    localparam int NUM_PORTS  = 4;
    localparam int DROP_CNT_W = 8;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 8'd255;

    typedef logic [NUM_PORTS-1:0] port_mask_t;

    // Isolates the lowest set bit, so port0 has highest priority; zero stays zero.
    function automatic port_mask_t decode_select(input port_mask_t sel);
        return sel & (~sel + port_mask_t'(1));
    endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One-entry valid/ready output register: holds a word until the consumer takes it.
module demux_out_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             can_accept
);

    // Empty, or draining this cycle: a refill lands with no bubble.
    assign can_accept = !out_valid || out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            // NOTE: the data word is reset too, so outputs are defined
            // immediately on reset rather than holding stale contents.
            out_data  <= '0;
        end else if (wr_en) begin
            out_valid <= 1'b1;
            out_data  <= wr_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_dispatch.sv
// Priority-decoded 1-to-4 stream demux with per-port output slots and a
// saturating counter of words dropped for an empty select.
module demux_dispatch
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    input  logic [3:0]            in_select,
    output logic [3:0]            out_valid,
    input  logic [3:0]            out_ready,
    output logic [WIDTH-1:0]      out_data0,
    output logic [WIDTH-1:0]      out_data1,
    output logic [WIDTH-1:0]      out_data2,
    output logic [WIDTH-1:0]      out_data3,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    port_mask_t       sel_onehot;
    port_mask_t       slot_can_accept;
    port_mask_t       slot_wr_en;
    logic             accept;
    logic             drop_accept;
    logic [WIDTH-1:0] slot_data [NUM_PORTS];

    assign sel_onehot = decode_select(in_select);

    // NOTE: in_ready gets its default first so no path through this block
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        in_ready = 1'b1;
        if (sel_onehot != '0) begin
            in_ready = |(sel_onehot & slot_can_accept);
        end
    end

    assign accept      = in_valid && in_ready;
    assign slot_wr_en  = accept ? sel_onehot : '0;
    assign drop_accept = accept && (sel_onehot == '0);

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_slot
        demux_out_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk        (clk),
            .rst_n      (rst_n),
            .wr_en      (slot_wr_en[i]),
            .wr_data    (in_data),
            .out_ready  (out_ready[i]),
            .out_valid  (out_valid[i]),
            .out_data   (slot_data[i]),
            .can_accept (slot_can_accept[i])
        );
    end

    assign out_data0 = slot_data[0];
    assign out_data1 = slot_data[1];
    assign out_data2 = slot_data[2];
    assign out_data3 = slot_data[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop_accept && (drop_cnt != DROP_CNT_MAX)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_demux_dispatch.sv
// Directed bench for demux_dispatch: decode priority, stall/refill, drop counter
// saturation and asynchronous reset.
module tb_demux_dispatch;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [3:0] in_select;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [7:0] out_data0;
    logic [7:0] out_data1;
    logic [7:0] out_data2;
    logic [7:0] out_data3;
    logic [7:0] drop_cnt;

    int checks = 0;
    int errors = 0;
    logic [3:0] seen_valid;

    demux_dispatch #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_select (in_select),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [3:0] sel, input logic [7:0] d);
        in_valid  = v;
        in_select = sel;
        in_data   = d;
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_select = 4'b0000;
        in_data   = 8'h00;
        out_ready = 4'b1111;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'h0);
        check("rst_out_data0", 32'(out_data0), 32'h0);
        check("rst_out_data3", 32'(out_data3), 32'h0);
        check("rst_in_ready_sel0", 32'(in_ready), 32'h1);

        // First cycle after release: select 0110 goes to port1.
        #10;
        rst_n = 1'b1;
        offer(1'b1, 4'b0110, 8'hA5);
        check("first_in_ready", 32'(in_ready), 32'h1);
        tick();
        check("first_out_valid", 32'(out_valid), 32'h2);
        check("first_out_data1", 32'(out_data1), 32'hA5);
        offer(1'b0, 4'b0000, 8'h00);
        tick();
        check("first_drained", 32'(out_valid), 32'h0);

        // Stall port0, then drain and refill in the same cycle.
        out_ready = 4'b1110;
        offer(1'b1, 4'b0001, 8'h11);
        tick();
        check("stall_valid", 32'(out_valid), 32'h1);
        check("stall_data_first", 32'(out_data0), 32'h11);
        offer(1'b1, 4'b0001, 8'h22);
        check("stall_in_ready_low", 32'(in_ready), 32'h0);
        tick();
        check("stall_hold_data", 32'(out_data0), 32'h11);
        check("stall_hold_valid", 32'(out_valid), 32'h1);
        tick();
        check("stall_hold_data2", 32'(out_data0), 32'h11);
        out_ready = 4'b1111;
        #1;
        check("stall_in_ready_high", 32'(in_ready), 32'h1);
        tick();
        check("stall_second_word", 32'(out_data0), 32'h22);
        check("stall_second_valid", 32'(out_valid), 32'h1);
        offer(1'b0, 4'b0000, 8'h00);
        tick();
        check("stall_empty", 32'(out_valid), 32'h0);

        // Back-to-back on port3 with no bubble.
        offer(1'b1, 4'b1000, 8'h01);
        tick();
        check("b2b_valid_1", 32'(out_valid), 32'h8);
        check("b2b_data_1", 32'(out_data3), 32'h01);
        offer(1'b1, 4'b1000, 8'h02);
        check("b2b_in_ready", 32'(in_ready), 32'h1);
        tick();
        check("b2b_valid_2", 32'(out_valid), 32'h8);
        check("b2b_data_2", 32'(out_data3), 32'h02);
        offer(1'b1, 4'b1000, 8'h03);
        tick();
        check("b2b_valid_3", 32'(out_valid), 32'h8);
        check("b2b_data_3", 32'(out_data3), 32'h03);
        offer(1'b0, 4'b0000, 8'h00);
        tick();
        check("b2b_drained", 32'(out_valid), 32'h0);

        // Port1 stalled: blocked offer, then redirect to port2.
        out_ready = 4'b1101;
        offer(1'b1, 4'b0010, 8'h33);
        tick();
        check("redir_p1_full", 32'(out_valid), 32'h2);
        offer(1'b1, 4'b0010, 8'h44);
        check("redir_blocked", 32'(in_ready), 32'h0);
        offer(1'b1, 4'b0100, 8'h55);
        check("redir_open", 32'(in_ready), 32'h1);
        tick();
        check("redir_valid", 32'(out_valid), 32'h6);
        check("redir_data2", 32'(out_data2), 32'h55);
        check("redir_data1_kept", 32'(out_data1), 32'h33);
        offer(1'b0, 4'b0000, 8'h00);
        tick();
        check("redir_p2_drained", 32'(out_valid), 32'h2);
        out_ready = 4'b1111;
        tick();
        check("redir_all_empty", 32'(out_valid), 32'h0);

        // Idle cycles with select 0 must not count; then saturate drop_cnt.
        check("drop_idle_zero", 32'(drop_cnt), 32'h0);
        seen_valid = 4'b0000;
        offer(1'b1, 4'b0000, 8'hEE);
        for (int i = 0; i < 300; i++) begin
            tick();
            seen_valid = seen_valid | out_valid;
            if (i == 0)   check("drop_cnt_1", 32'(drop_cnt), 32'd1);
            if (i == 253) check("drop_cnt_254", 32'(drop_cnt), 32'd254);
            if (i == 254) check("drop_cnt_255", 32'(drop_cnt), 32'd255);
        end
        check("drop_cnt_sat", 32'(drop_cnt), 32'd255);
        check("drop_no_valid", 32'(seen_valid), 32'h0);
        offer(1'b0, 4'b0000, 8'h00);

        // Fill slots 0 and 2, reset between edges.
        out_ready = 4'b0000;
        offer(1'b1, 4'b0001, 8'h77);
        tick();
        offer(1'b1, 4'b0100, 8'h88);
        tick();
        offer(1'b0, 4'b0000, 8'h00);
        check("rst2_pre_valid", 32'(out_valid), 32'h5);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst2_async_valid", 32'(out_valid), 32'h0);
        check("rst2_async_drop", 32'(drop_cnt), 32'h0);
        check("rst2_async_data0", 32'(out_data0), 32'h0);
        check("rst2_async_data2", 32'(out_data2), 32'h0);
        out_ready = 4'b1111;
        offer(1'b1, 4'b0010, 8'h99);
        tick();
        check("rst2_no_xfer", 32'(out_valid), 32'h0);
        #2;
        rst_n = 1'b1;
        #1;
        check("rst2_rel_in_ready", 32'(in_ready), 32'h1);
        tick();
        check("rst2_rel_valid", 32'(out_valid), 32'h2);
        check("rst2_rel_data1", 32'(out_data1), 32'h99);
        offer(1'b0, 4'b0000, 8'h00);
        tick();
        check("rst2_rel_drained", 32'(out_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_dispatch.md
DEMUX_DISPATCH -- requirements
Module: demux_dispatch

Interface
REQ-001 Parameter WIDTH, default 8: data width of input and every output port, in bits.
REQ-002 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 Port rst_n, input, 1: asynchronous active-low reset.
REQ-004 Port in_valid, input, 1: an input word is offered.
REQ-005 Port in_ready, output, 1: the block accepts the offered word this cycle.
REQ-006 Port in_data, input, WIDTH: the input word.
REQ-007 Port in_select, input, 4: destination select; the lowest set bit has priority.
REQ-008 Ports out_valid[3:0] output, out_ready[3:0] input, out_data0..out_data3 output (WIDTH each): four output streams.
REQ-009 Port drop_cnt, output, 8: count of words dropped because in_select was 0; saturating.

Function
REQ-010 Decode shall be priority-based: bit0 set -> port0; else bit1 -> port1; else bit2 -> port2; else bit3 -> port3; 4'b0000 -> drop.
REQ-011 Each output port shall hold a one-entry register (slot) made of a valid flag and a WIDTH-bit data word.
REQ-012 A transfer on any interface shall occur only in a cycle where valid and ready are both 1.
REQ-013 in_ready shall be purely combinational and shall not depend on in_valid.
REQ-014 For select 4'b0000, in_ready shall be 1.
REQ-015 Otherwise, in_ready shall be 1 when the decoded slot is empty, or when its valid and out_ready are both 1 in this cycle.
REQ-016 An accepted word shall appear at the decoded port the next cycle: out_valid=1 and out_data equal to the accepted word, i.e. latency 1.
REQ-017 While out_valid=1 and out_ready=0, out_data shall stay stable.
REQ-018 While out_valid=1 and out_ready=0, out_valid shall stay 1.
REQ-019 Drain with no refill: the slot shall go empty the cycle after the drain.
REQ-020 Drain and refill in the same cycle: the slot shall hold the new word and out_valid shall stay 1 with no bubble.
REQ-021 Only the decoded slot shall be written; the other three slots shall drain independently in parallel.
REQ-022 Each accepted word with select 4'b0000 shall be discarded and shall increment drop_cnt by 1.
REQ-023 drop_cnt shall saturate at 255 and never wrap.
REQ-024 in_select and in_data shall be sampled only on an accepted transfer; their values are don't-care when in_valid=0.
REQ-025 out_dataN shall hold its last value when the slot is empty; its contents are unspecified for checking purposes.

Reset
REQ-026 When rst_n=0, all out_valid bits shall clear to 0 immediately, without waiting for a clock edge.
REQ-027 When rst_n=0, drop_cnt shall clear to 0 immediately.
REQ-028 When rst_n=0, all out_data words shall clear to 0 immediately.
REQ-029 Reset mid-operation shall discard all buffered words; no transfer shall occur in a cycle where rst_n=0.
REQ-030 The first accept after reset shall be possible in the first cycle with rst_n=1.

Structure
REQ-031 Package demux_pkg shall hold NUM_PORTS=4, DROP_CNT_W=8 and DROP_CNT_MAX=255.
REQ-032 Sub-module demux_out_slot (one-entry valid/ready register, WIDTH parameter) shall be instantiated NUM_PORTS times.
REQ-033 The top level shall hold only the priority decode, the in_ready mux and the drop counter.

Verification
REQ-034 Reset release, in_valid=1, select=4'b0110, data=8'hA5 -> next cycle out_valid=4'b0010 and out_data1=8'hA5; ports 0, 2 and 3 stay idle.
REQ-035 Hold out_ready0=0, send 8'h11 then 8'h22 to select 4'b0001 -> second word sees in_ready=0; out_data0 stays 8'h11 until out_ready0=1; 8'h22 appears the following cycle.
REQ-036 out_ready3=1 held, back-to-back words 8'h01, 8'h02, 8'h03 with select 4'b1000 -> out_valid3 stays 1 for three consecutive cycles with data 01, 02, 03 and no bubble.
REQ-037 300 accepted words with select 4'b0000 -> drop_cnt reads 255; no out_valid bit is ever asserted.
REQ-038 Slots 0 and 2 full, assert rst_n=0 between clock edges -> out_valid=4'b0000 and drop_cnt=0 before the next edge; a word sent the first cycle after release is delivered normally.
REQ-039 Port1 full and stalled, offer a word with select 4'b0010, then switch the offer to select 4'b0100 -> in_ready goes 0 then 1; word lands at port2 only.
